// File: rtl/vectrans2_mul_pipe.sv
// Configurable-depth pipelined multiplier with valid/ready flow control,
// per-transaction signed/unsigned mode and overflow detection with optional saturation.
module vectrans2_mul_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 32,
    parameter int dout_WIDTH = 32,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  is_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int PW = din0_WIDTH + din1_WIDTH;

    if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_stage
        $error("vectrans2_mul_pipe: NUM_STAGE=%0d outside 1..8", NUM_STAGE);
    end
    if (din0_WIDTH < 1 || din1_WIDTH < 1) begin : g_bad_din
        $error("vectrans2_mul_pipe: operand widths must be at least 1");
    end
    if (dout_WIDTH < 2 || dout_WIDTH > PW) begin : g_bad_dout
        $error("vectrans2_mul_pipe: dout_WIDTH=%0d outside 2..%0d", dout_WIDTH, PW);
    end
    if (ID < 0) begin : g_bad_id
        $error("vectrans2_mul_pipe: ID must be non-negative");
    end

    logic advance;
    logic accept;

    // The whole pipe moves as one; the output register frees up when consumed.
    assign advance  = ce & (~out_valid | out_ready);
    assign in_ready = advance;
    assign accept   = in_valid & advance;

    logic [PW-1:0] ext0;
    logic [PW-1:0] ext1;
    logic [PW-1:0] prod;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        ext0 = {{din1_WIDTH{1'b0}}, din0};
        ext1 = {{din0_WIDTH{1'b0}}, din1};
        if (is_signed) begin
            ext0 = {{din1_WIDTH{din0[din0_WIDTH-1]}}, din0};
            ext1 = {{din0_WIDTH{din1[din1_WIDTH-1]}}, din1};
        end
        // The low PW bits of the extended product are exact in both modes.
        prod = ext0 * ext1;
    end

    logic [PW-1:0] fin_p;
    logic          fin_s;
    logic          fin_v;

    if (NUM_STAGE == 1) begin : g_single
        assign fin_p = prod;
        assign fin_s = is_signed;
        assign fin_v = accept;
    end else begin : g_pipe
        localparam int MID = NUM_STAGE - 1;

        logic [PW-1:0]  p_q [MID];
        logic [MID-1:0] s_q;
        logic [MID-1:0] v_q;

        // NOTE: product registers are cleared with the valid bits so reset leaves no stale data.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k < MID; k++) begin
                    p_q[k] <= '0;
                end
                s_q <= '0;
                v_q <= '0;
            end else if (advance) begin
                p_q[0] <= prod;
                s_q[0] <= is_signed;
                v_q[0] <= accept;
                for (int k = 1; k < MID; k++) begin
                    p_q[k] <= p_q[k-1];
                    s_q[k] <= s_q[k-1];
                    v_q[k] <= v_q[k-1];
                end
            end
        end

        assign fin_p = p_q[MID-1];
        assign fin_s = s_q[MID-1];
        assign fin_v = v_q[MID-1];
    end

    function automatic logic [dout_WIDTH:0] finish_result(input logic [PW-1:0] p,
                                                          input logic          sgn);
        logic                  o;
        logic [dout_WIDTH-1:0] r;
        o = 1'b0;
        // Bits above the result must all be zero (unsigned) or copies of the result MSB (signed).
        for (int i = dout_WIDTH; i < PW; i++) begin
            if (sgn ? (p[i] != p[dout_WIDTH-1]) : p[i]) begin
                o = 1'b1;
            end
        end
        r = p[dout_WIDTH-1:0];
        if (o && SATURATE != 0) begin
            if (!sgn) begin
                r = '1;
            end else if (p[PW-1]) begin
                r = {1'b1, {(dout_WIDTH-1){1'b0}}};
            end else begin
                r = {1'b0, {(dout_WIDTH-1){1'b1}}};
            end
        end
        return {o, r};
    endfunction

    logic [dout_WIDTH:0] fin_res;
    assign fin_res = finish_result(fin_p, fin_s);

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            ovf       <= 1'b0;
        end else if (advance) begin
            out_valid <= fin_v;
            if (fin_v) begin
                dout <= fin_res[dout_WIDTH-1:0];
                ovf  <= fin_res[dout_WIDTH];
            end
        end
    end

endmodule
